// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multicycle core: fetch/operand/execute/memory/writeback with run/stop/step control
// Optional breakpoint ports and logic are built when MCORE_BREAKPOINT_EN is defined.
module multicycle_core #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int IN_WIDTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  step,
  input  logic [IN_WIDTH-1:0]   in,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [15:0]           imem_data,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_phase,
  output logic                  running,
  output logic                  halted
`ifdef MCORE_BREAKPOINT_EN
  ,
  input  logic                  bp_en,
  input  logic [ADDR_WIDTH-1:0] bp_addr,
  output logic                  bp_hit
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_P4, S_P5, S_HALT} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] pc;
  logic [15:0]           ir;
  logic [DATA_WIDTH-1:0] regs [8];
  logic [DATA_WIDTH-1:0] mdr;
  logic                  flag_s, flag_z, flag_c, flag_v;
  logic                  stop_req;

  logic [1:0]            cls;
  logic [2:0]            ra, rb;
  logic [3:0]            op, sh;
  logic [DATA_WIDTH-1:0] a, b, d_data, eff_addr, alu_res;
  logic [ADDR_WIDTH-1:0] d_addr, pc_nxt;
  logic                  alu_c, alu_v, alu_wr, alu_flags;
  logic                  is_alu, is_load, is_store, is_mem, is_li, is_halt, is_out;
  logic                  br_cond, br_taken, stop_pend, bp_stop;

  assign cls      = ir[15:14];
  assign rb       = ir[13:11];
  assign ra       = ir[10:8];
  assign op       = ir[7:4];
  assign sh       = ir[3:0];
  assign d_data   = {{(DATA_WIDTH-8){ir[7]}}, ir[7:0]};
  assign d_addr   = {{(ADDR_WIDTH-8){ir[7]}}, ir[7:0]};
  assign a        = regs[ra];
  assign b        = regs[rb];
  assign eff_addr = a + d_data;

  assign is_alu   = (cls == 2'b11);
  assign is_load  = (cls == 2'b00);
  assign is_store = (cls == 2'b01);
  assign is_mem   = is_load | is_store;
  assign is_li    = (cls == 2'b10) && (rb == 3'b000);
  assign is_halt  = is_alu && (op == 4'hF);
  assign is_out   = is_alu && (op == 4'hD);

  always_comb begin
    br_cond = 1'b0;
    case (ra)
      3'b000:  br_cond = flag_z;
      3'b001:  br_cond = flag_s ^ flag_v;
      3'b010:  br_cond = flag_z | (flag_s ^ flag_v);
      3'b011:  br_cond = !flag_z;
      default: br_cond = 1'b0;
    endcase
  end

  assign br_taken  = (cls == 2'b10) && ((rb == 3'b100) || ((rb == 3'b111) && br_cond));
  assign pc_nxt    = br_taken ? pc + d_addr : pc;
  // An exec arriving in P5 itself still counts as a stop for the instruction retiring now.
  assign stop_pend = stop_req | exec;

`ifdef MCORE_BREAKPOINT_EN
  assign bp_stop = running && bp_en && (pc_nxt == bp_addr);
`else
  assign bp_stop = 1'b0;
`endif

  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_wr    = 1'b0;
    alu_flags = 1'b0;
    if (is_alu) begin
      case (op)
        4'h0: begin
          {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
          alu_v     = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (alu_res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
          alu_wr    = 1'b1;
          alu_flags = 1'b1;
        end
        4'h1, 4'h5: begin
          {alu_c, alu_res} = {1'b0, a} - {1'b0, b};
          alu_v     = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (alu_res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
          alu_wr    = (op == 4'h1);
          alu_flags = 1'b1;
        end
        4'h2: begin alu_res = a & b; alu_wr = 1'b1; alu_flags = 1'b1; end
        4'h3: begin alu_res = a | b; alu_wr = 1'b1; alu_flags = 1'b1; end
        4'h4: begin alu_res = a ^ b; alu_wr = 1'b1; alu_flags = 1'b1; end
        4'h6: begin alu_res = b;     alu_wr = 1'b1; alu_flags = 1'b1; end
        4'h8: begin alu_res = a << sh; alu_wr = 1'b1; alu_flags = 1'b1; end
        4'h9: begin
          alu_res   = (a << sh) | (a >> (DATA_WIDTH - int'(sh)));
          alu_wr    = 1'b1;
          alu_flags = 1'b1;
        end
        4'hA: begin alu_res = a >> sh; alu_wr = 1'b1; alu_flags = 1'b1; end
        4'hB: begin alu_res = $signed(a) >>> sh; alu_wr = 1'b1; alu_flags = 1'b1; end
        4'hC: begin alu_res = DATA_WIDTH'(in); alu_wr = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (exec || step) state_nxt = S_P1;
      S_P1:    if (imem_ack) state_nxt = S_P2;
      S_P2:    state_nxt = S_P3;
      S_P3:    state_nxt = is_halt ? S_HALT : S_P4;
      S_P4:    if (!is_mem || dmem_ack) state_nxt = S_P5;
      S_P5:    state_nxt = (running && !stop_pend && !bp_stop) ? S_P1 : S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc         <= '0;
      ir         <= '0;
      mdr        <= '0;
      flag_s     <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      out_result <= '0;
      running    <= 1'b0;
      halted     <= 1'b0;
      stop_req   <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
`ifdef MCORE_BREAKPOINT_EN
      bp_hit     <= 1'b0;
`endif
    end else begin
      if (running && exec && (state inside {S_P1, S_P2, S_P3, S_P4})) stop_req <= 1'b1;
      case (state)
        S_IDLE: begin
          if (exec) running <= 1'b1;
`ifdef MCORE_BREAKPOINT_EN
          if (exec || step) bp_hit <= 1'b0;
`endif
        end
        S_P1: if (imem_ack) begin
          ir <= imem_data;
          pc <= pc + ADDR_WIDTH'(1);
        end
        S_P3: begin
          if (is_out) out_result <= a;
          if (is_halt) begin
            halted   <= 1'b1;
            running  <= 1'b0;
            stop_req <= 1'b0;
          end
        end
        S_P4: if (is_load && dmem_ack) mdr <= dmem_rdata;
        S_P5: begin
          if (alu_wr) regs[ra] <= alu_res;
          if (is_li)  regs[ra] <= d_data;
          if (is_load) regs[rb] <= mdr;
          if (alu_flags) begin
            flag_s <= alu_res[DATA_WIDTH-1];
            flag_z <= (alu_res == '0);
            flag_c <= alu_c;
            flag_v <= alu_v;
          end
          pc <= pc_nxt;
          if (stop_pend || bp_stop) begin
            running  <= 1'b0;
            stop_req <= 1'b0;
          end
`ifdef MCORE_BREAKPOINT_EN
          if (bp_stop && !stop_pend) bp_hit <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = (state == S_P1);
  assign imem_addr  = pc;
  assign dmem_req   = (state == S_P4) && is_mem;
  assign dmem_we    = (state == S_P4) && is_store;
  assign dmem_addr  = ADDR_WIDTH'(eff_addr);
  assign dmem_wdata = b;

  always_comb begin
    out_phase = 5'b00000;
    case (state)
      S_P1:    out_phase = 5'b00001;
      S_P2:    out_phase = 5'b00010;
      S_P3:    out_phase = 5'b00100;
      S_P4:    out_phase = 5'b01000;
      S_P5:    out_phase = 5'b10000;
      default: out_phase = 5'b00000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - bench for multicycle_core: ISA-level model plus directed programs
module tb_multicycle_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        exec = 1'b0;
  logic        step = 1'b0;
  logic [3:0]  in_val = 4'h0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = 16'h0;
  logic [15:0] out_result;
  logic [4:0]  out_phase;
  logic        running, halted;
`ifdef MCORE_BREAKPOINT_EN
  logic        bp_hit;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_core dut (
    .clock(clock), .reset(reset), .exec(exec), .step(step), .in(in_val),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_result(out_result), .out_phase(out_phase), .running(running), .halted(halted)
`ifdef MCORE_BREAKPOINT_EN
    , .bp_en(1'b0), .bp_addr(16'h0), .bp_hit(bp_hit)
`endif
  );

  always #5 clock = ~clock;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] prog [$];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  int p1_cycles = 0, we_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory responders: ack after a programmable number of wait cycles.
  always @(negedge clock) begin
    if (imem_req) begin
      if (icnt >= iwait) begin imem_ack = 1'b1; imem_data = imem[imem_addr[7:0]]; end
      else begin imem_ack = 1'b0; icnt++; end
    end else begin
      imem_ack = 1'b0; icnt = 0;
    end
    if (dmem_req) begin
      if (dcnt >= dwait) begin
        dmem_ack = 1'b1;
        if (dmem_we) dmem[dmem_addr[7:0]] = dmem_wdata;
        else dmem_rdata = dmem[dmem_addr[7:0]];
      end else begin dmem_ack = 1'b0; dcnt++; end
    end else begin
      dmem_ack = 1'b0; dcnt = 0;
    end
  end

  // Architectural model
  logic [15:0] m_r [8];
  logic [15:0] m_dmem [256];
  logic [15:0] m_pc, m_out, m_daddr, m_dwdata;
  logic        m_s, m_z, m_c, m_v, m_halt;
  logic [1:0]  m_cls;

  task automatic m_reset();
    for (int k = 0; k < 8; k++) m_r[k] = 16'h0;
    m_pc = 0; m_out = 0; m_s = 0; m_z = 0; m_c = 0; m_v = 0; m_halt = 0; m_cls = 2'b10;
  endtask

  function automatic int sx(input logic [15:0] x);
    return x[15] ? int'(x) - 65536 : int'(x);
  endfunction

  task automatic m_step();
    logic [15:0] i, a, b, d, res;
    logic [2:0]  ra, rb;
    int op, sh, ires, sr;
    logic upd, wr, c, v, taken;
    i = imem[m_pc[7:0]];
    m_pc = m_pc + 16'd1;
    ra = i[10:8]; rb = i[13:11]; op = int'(i[7:4]); sh = int'(i[3:0]);
    d = {{8{i[7]}}, i[7:0]};
    a = m_r[ra]; b = m_r[rb];
    m_cls = i[15:14];
    m_daddr = a + d; m_dwdata = b;
    upd = 0; wr = 0; c = 0; v = 0; ires = 0;
    case (i[15:14])
      2'b11: begin
        case (op)
          0: begin ires = int'(a) + int'(b); c = ires > 65535; sr = sx(a) + sx(b);
                   v = sr > 32767 || sr < -32768; upd = 1; wr = 1; end
          1, 5: begin ires = int'(a) - int'(b); c = a < b; sr = sx(a) - sx(b);
                   v = sr > 32767 || sr < -32768; upd = 1; wr = (op == 1); end
          2: begin ires = int'(a & b); upd = 1; wr = 1; end
          3: begin ires = int'(a | b); upd = 1; wr = 1; end
          4: begin ires = int'(a ^ b); upd = 1; wr = 1; end
          6: begin ires = int'(b); upd = 1; wr = 1; end
          8: begin ires = int'(a) << sh; upd = 1; wr = 1; end
          9: begin ires = (int'(a) << sh) | (int'(a) >> (16 - sh)); upd = 1; wr = 1; end
          10: begin ires = int'(a) >> sh; upd = 1; wr = 1; end
          11: begin ires = sx(a) >>> sh; upd = 1; wr = 1; end
          12: begin ires = int'(in_val); wr = 1; end
          13: m_out = a;
          15: m_halt = 1;
          default: ;
        endcase
        res = ires[15:0];
        if (wr) m_r[ra] = res;
        if (upd) begin m_s = res[15]; m_z = (res == 16'h0); m_c = c; m_v = v; end
      end
      2'b00: m_r[rb] = m_dmem[m_daddr[7:0]];
      2'b01: m_dmem[m_daddr[7:0]] = b;
      default: begin
        if (rb == 3'b000) m_r[ra] = d;
        else begin
          taken = (rb == 3'b100) ||
                  (rb == 3'b111 && ((ra == 0 && m_z) || (ra == 1 && (m_s ^ m_v)) ||
                                    (ra == 2 && (m_z | (m_s ^ m_v))) || (ra == 3 && !m_z)));
          if (taken) m_pc = m_pc + d;
        end
      end
    endcase
  endtask

  task automatic compare_state();
    for (int k = 0; k < 8; k++) chk($sformatf("r%0d", k), dut.regs[k], m_r[k]);
    chk("flag_s", dut.flag_s, m_s);
    chk("flag_z", dut.flag_z, m_z);
    chk("flag_c", dut.flag_c, m_c);
    chk("flag_v", dut.flag_v, m_v);
    chk("out_result", out_result, m_out);
    chk("halted", halted, m_halt);
  endtask

  logic [4:0] prev_phase = 5'b0;

  always @(negedge clock) begin
    if (reset) begin
      chk("imem_req", imem_req, out_phase == 5'b00001);
      if (out_phase == 5'b00001) begin
        p1_cycles++;
        chk("imem_addr", imem_addr, m_pc);
      end
      if (out_phase == 5'b00010 && prev_phase != 5'b00010) m_step();
      chk("dmem_req", dmem_req, out_phase == 5'b01000 && m_cls <= 2'b01);
      chk("dmem_we", dmem_we, out_phase == 5'b01000 && m_cls == 2'b01);
      if (dmem_we) we_cycles++;
      if (out_phase == 5'b01000 && m_cls <= 2'b01) chk("dmem_addr", dmem_addr, m_daddr);
      if (out_phase == 5'b01000 && m_cls == 2'b01) chk("dmem_wdata", dmem_wdata, m_dwdata);
      if (out_phase == 5'b00000 || (out_phase == 5'b00001 && prev_phase != 5'b00001)) compare_state();
      if (out_phase == 5'b00000) chk("idle_running", running, 1'b0);
    end
    prev_phase = out_phase;
  end

  task automatic start_test(input int iw, input int dw);
    reset = 1'b0;
    iwait = iw; dwait = dw;
    for (int k = 0; k < 256; k++) begin
      imem[k]   = (k < prog.size()) ? prog[k] : 16'hC0F0;
      dmem[k]   = 16'hA000 + 16'(k);
      m_dmem[k] = 16'hA000 + 16'(k);
    end
    m_reset();
    p1_cycles = 0; we_cycles = 0;
    @(negedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic pulse(input logic do_exec, input logic do_step);
    @(negedge clock);
    exec = do_exec; step = do_step;
    @(negedge clock);
    exec = 1'b0; step = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (out_phase != 5'b0 && n < budget) begin @(negedge clock); n++; end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s timeout phase=%0h", name, out_phase);
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_phase", out_phase, 5'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_out", out_result, 16'h0);
    chk("rst_pc", imem_addr, 16'h0);

    // LI r1,5; LI r2,-3; ADD r1,r2; OUT r1; HALT (zero wait, then 3-cycle fetch wait)
    for (int w = 0; w < 4; w += 3) begin
      prog = '{16'h8105, 16'h82FD, 16'hD100, 16'hC1D0, 16'hC0F0};
      start_test(w, 0);
      pulse(1'b1, 1'b0);
      wait_idle("t1_run", 200);
      chk("t1_out", out_result, 16'h0002);
      chk("t1_halted", halted, 1'b1);
      chk("t1_z", dut.flag_z, 1'b0);
      chk("t1_c", dut.flag_c, 1'b1);
      chk("t1_s", dut.flag_s, 1'b0);
      chk("t1_p1_cycles", p1_cycles, 5 * (w + 1));
    end

    // build 0x1234, store to 10, load into r3 with 2-cycle data wait
    prog = '{16'h8112, 16'hC188, 16'h8434, 16'hE130, 16'h820A, 16'h4A00, 16'h1A00, 16'hC3D0, 16'hC0F0};
    start_test(0, 2);
    pulse(1'b1, 1'b0);
    wait_idle("t3_run", 300);
    chk("t3_out", out_result, 16'h1234);
    chk("t3_r3", dut.regs[3], 16'h1234);
    chk("t3_mem10", dmem[10], 16'h1234);
    chk("t3_we_cycles", we_cycles, 3);

    // CMP 0x8000,1 then BLT +2 skips two LIs
    prog = '{16'h8101, 16'hC18F, 16'h8201, 16'hD150, 16'hB902, 16'h8555, 16'h8555, 16'hC1D0, 16'hC0F0};
    start_test(0, 0);
    pulse(1'b1, 1'b0);
    wait_idle("t4_run", 300);
    chk("t4_out", out_result, 16'h8000);
    chk("t4_r5", dut.regs[5], 16'h0000);
    chk("t4_v", dut.flag_v, 1'b1);
    chk("t4_s", dut.flag_s, 1'b0);
    chk("t4_p1_cycles", p1_cycles, 7);

    // countdown loop with BNE: 3+2+1
    prog = '{16'h8103, 16'h8201, 16'h8300, 16'hCB00, 16'hD110, 16'hBBFD, 16'hC3D0, 16'hC0F0};
    start_test(0, 0);
    pulse(1'b1, 1'b0);
    wait_idle("t5_run", 500);
    chk("t5_out", out_result, 16'h0006);

    // IN, SRA, rotate, XOR, MOV, SRL
    prog = '{16'hC1C0, 16'h8280, 16'hC2B4, 16'hC294, 16'hD140, 16'hCC60, 16'hC4A8, 16'hC4D0, 16'hC0F0};
    in_val = 4'hA;
    start_test(0, 0);
    pulse(1'b1, 1'b0);
    wait_idle("t6_run", 300);
    chk("t6_out", out_result, 16'h00FF);
    chk("t6_r2", dut.regs[2], 16'hFF8F);

    // stop mid-P2, then step, then exec+step together
    prog = '{16'h8101, 16'h8202, 16'h8303, 16'hC0F0};
    start_test(0, 0);
    pulse(1'b1, 1'b0);
    for (int n = 0; n < 20 && out_phase != 5'b00010; n++) @(negedge clock);
    chk("t7_in_p2", out_phase, 5'b00010);
    exec = 1'b1;
    @(negedge clock);
    exec = 1'b0;
    wait_idle("t7_stop", 50);
    chk("t7_r1", dut.regs[1], 16'h0001);
    chk("t7_r2", dut.regs[2], 16'h0000);
    chk("t7_p1_cycles", p1_cycles, 1);
    pulse(1'b0, 1'b1);
    wait_idle("t7_step", 50);
    chk("t7_step_r2", dut.regs[2], 16'h0002);
    chk("t7_step_r3", dut.regs[3], 16'h0000);
    chk("t7_step_p1", p1_cycles, 2);
    chk("t7_step_halted", halted, 1'b0);
    pulse(1'b1, 1'b1);
    wait_idle("t7_both", 100);
    chk("t7_both_r3", dut.regs[3], 16'h0003);
    chk("t7_both_halted", halted, 1'b1);

    // reset while a store handshake is pending
    prog = '{16'h8112, 16'hC188, 16'h8434, 16'hE130, 16'h820A, 16'h4A00, 16'h1A00, 16'hC3D0, 16'hC0F0};
    start_test(0, 20);
    pulse(1'b1, 1'b0);
    for (int n = 0; n < 100 && !dmem_req; n++) @(negedge clock);
    chk("t8_req_seen", dmem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("t8_dmem_req", dmem_req, 1'b0);
    chk("t8_dmem_we", dmem_we, 1'b0);
    chk("t8_imem_req", imem_req, 1'b0);
    chk("t8_phase", out_phase, 5'b0);
    chk("t8_running", running, 1'b0);
    chk("t8_out", out_result, 16'h0);
    chk("t8_r1", dut.regs[1], 16'h0);
    chk("t8_pc", imem_addr, 16'h0);
    m_reset();
    dwait = 0;
    @(negedge clock);
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
